// File: rtl/frost32_mem_bridge.sv
// Frost32 memory bridge: turns one 8/16/32-bit CPU access into a sequence of
// big-endian byte accesses on a byte-wide synchronous RAM. Read data is returned
// right-aligned and zero-extended, and completion is signalled by a one-cycle ack.
module frost32_mem_bridge #(
    parameter int unsigned ADDR_WIDTH = 24
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cpu_req,
    input  logic                  i_cpu_write,
    input  logic [1:0]            i_cpu_size,
    input  logic [31:0]           i_cpu_addr,
    input  logic [31:0]           i_cpu_wr_data,
    output logic [31:0]           o_cpu_rd_data,
    output logic                  o_cpu_ack,
    output logic                  o_cpu_busy,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic                  o_ram_wr_en,
    output logic [7:0]            o_ram_wr_data,
    input  logic [7:0]            i_ram_rd_data
);

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StRtail,
        StDone
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_base;
    logic                  r_write;
    logic [1:0]            r_last;     // index of the final byte, i.e. N-1
    logic [31:0]           r_wdata;
    logic [1:0]            r_idx;
    logic [31:0]           r_acc;
    logic [31:0]           r_rd_data;
    logic [1:0]            w_last_in;
    logic [1:0]            w_byte_sel;
    logic                  w_unused;

    // Upper address bits beyond the RAM width are intentionally discarded.
    assign w_unused = ^i_cpu_addr;

    // Size 0/1/2/3 -> N = 4/2/1/1, stored as N-1.
    assign w_last_in = (i_cpu_size == 2'd0) ? 2'd3 :
                       (i_cpu_size == 2'd1) ? 2'd1 : 2'd0;

    // MSB first: byte (N-1-idx) of the right-aligned write word.
    assign w_byte_sel = 2'(r_last - r_idx);

    assign o_cpu_rd_data = r_rd_data;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request latch, byte index and read accumulator.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_base    <= '0;
            r_write   <= 1'b0;
            r_last    <= 2'd0;
            r_wdata   <= 32'd0;
            r_idx     <= 2'd0;
            r_acc     <= 32'd0;
            r_rd_data <= 32'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_cpu_req) begin
                        r_base  <= i_cpu_addr[ADDR_WIDTH-1:0];
                        r_write <= i_cpu_write;
                        r_last  <= w_last_in;
                        r_wdata <= i_cpu_wr_data;
                        r_idx   <= 2'd0;
                        r_acc   <= 32'd0;
                    end
                end
                StXfer: begin
                    r_idx <= 2'(r_idx + 2'd1);
                    // RAM data lags the address by one cycle, so idx 0 has nothing yet.
                    if (r_idx != 2'd0) begin
                        r_acc <= {r_acc[23:0], i_ram_rd_data};
                    end
                end
                StRtail: begin
                    r_acc     <= {r_acc[23:0], i_ram_rd_data};
                    // Publish now so the result is already visible in the ack cycle.
                    r_rd_data <= {r_acc[23:0], i_ram_rd_data};
                end
                StDone: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and RAM/CPU handshake outputs.
    always_comb begin
        w_state_next  = r_state;
        o_cpu_ack     = 1'b0;
        o_cpu_busy    = 1'b1;
        o_ram_addr    = '0;
        o_ram_wr_en   = 1'b0;
        o_ram_wr_data = 8'd0;
        unique case (r_state)
            StIdle: begin
                o_cpu_busy = 1'b0;
                if (i_cpu_req) begin
                    w_state_next = StXfer;
                end
            end
            StXfer: begin
                o_ram_addr    = r_base + ADDR_WIDTH'(r_idx);
                o_ram_wr_en   = r_write;
                o_ram_wr_data = r_wdata[{w_byte_sel, 3'b000} +: 8];
                if (r_idx == r_last) begin
                    w_state_next = r_write ? StDone : StRtail;
                end
            end
            StRtail: begin
                w_state_next = StDone;
            end
            StDone: begin
                o_cpu_ack    = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_frost32_mem_bridge.sv
// Bench for frost32_mem_bridge: byte RAM model, reference memory model and a
// scoreboard that checks every ack for read data and latency.
module tb_frost32_mem_bridge;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_write;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wr_data;
    logic [31:0] cpu_rd_data;
    logic        cpu_ack;
    logic        cpu_busy;
    logic [23:0] ram_addr;
    logic        ram_wr_en;
    logic [7:0]  ram_wr_data;
    logic [7:0]  ram_rd_data;

    frost32_mem_bridge #(.ADDR_WIDTH(24)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_cpu_req     (cpu_req),
        .i_cpu_write   (cpu_write),
        .i_cpu_size    (cpu_size),
        .i_cpu_addr    (cpu_addr),
        .i_cpu_wr_data (cpu_wr_data),
        .o_cpu_rd_data (cpu_rd_data),
        .o_cpu_ack     (cpu_ack),
        .o_cpu_busy    (cpu_busy),
        .o_ram_addr    (ram_addr),
        .o_ram_wr_en   (ram_wr_en),
        .o_ram_wr_data (ram_wr_data),
        .i_ram_rd_data (ram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte RAM driven by the DUT.
    logic [7:0] ram [int unsigned];
    always @(posedge clk) begin
        if (ram_wr_en) ram[{8'h00, ram_addr}] = ram_wr_data;
        ram_rd_data <= ram.exists({8'h00, ram_addr}) ? ram[{8'h00, ram_addr}] : 8'h00;
    end

    // Reference memory, updated by the model at issue time.
    logic [7:0]  ref_mem [int unsigned];
    logic [31:0] last_rd = 32'd0;

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] ram_byte(input logic [23:0] a);
        return ram.exists({8'h00, a}) ? ram[{8'h00, a}] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [23:0] a);
        return ref_mem.exists({8'h00, a}) ? ref_mem[{8'h00, a}] : 8'h00;
    endfunction

    // Big-endian access over N bytes starting at addr mod 2^24.
    task automatic model_push(input logic w, input logic [1:0] sz, input logic [31:0] addr,
                              input logic [31:0] data, input int acc);
        int          n;
        logic [23:0] a;
        logic [31:0] rd;
        exp_t        e;
        n  = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
        rd = 32'd0;
        for (int i = 0; i < n; i++) begin
            a = addr[23:0] + 24'(i);
            if (w) ref_mem[{8'h00, a}] = data[8*(n-1-i) +: 8];
            else   rd = (rd << 8) | {24'd0, ref_byte(a)};
        end
        if (!w) last_rd = rd;
        e.data = last_rd;
        e.lat  = w ? n + 1 : n + 2;
        e.acc  = acc;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && cpu_ack) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: ack seen with no outstanding request (cycle %0d)",
                         cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ack_rd_data", cpu_rd_data, e.data);
                check("ack_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!cpu_busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy stuck high, expected low (cycle %0d)", cyc);
        end
    endtask

    task automatic wait_ack();
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: no ack, expected one within 20 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] data);
        int a;
        wait_idle();
        cpu_req     = 1'b1;
        cpu_write   = w;
        cpu_size    = sz;
        cpu_addr    = addr;
        cpu_wr_data = data;
        @(posedge clk);
        #1;
        a       = cyc;
        cpu_req = 1'b0;
        model_push(w, sz, addr, data, a);
        wait_ack();
    endtask

    initial begin
        int a;
        rst_n       = 1'b0;
        cpu_req     = 1'b0;
        cpu_write   = 1'b0;
        cpu_size    = 2'd0;
        cpu_addr    = 32'd0;
        cpu_wr_data = 32'd0;

        // Reset and idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {31'd0, cpu_ack}, 32'd0);
        check("rst_busy", {31'd0, cpu_busy}, 32'd0);
        check("rst_rd_data", cpu_rd_data, 32'd0);
        check("rst_wr_en", {31'd0, ram_wr_en}, 32'd0);
        check("rst_ram_addr", {8'd0, ram_addr}, 32'd0);
        check("rst_wr_data", {24'd0, ram_wr_data}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_wr_en", {31'd0, ram_wr_en}, 32'd0);
        end

        // 32-bit write then read back.
        do_req(1'b1, 2'd0, 32'h0000_0100, 32'hDEAD_BEEF);
        check("w32_b0", {24'd0, ram_byte(24'h000100)}, 32'hDE);
        check("w32_b1", {24'd0, ram_byte(24'h000101)}, 32'hAD);
        check("w32_b2", {24'd0, ram_byte(24'h000102)}, 32'hBE);
        check("w32_b3", {24'd0, ram_byte(24'h000103)}, 32'hEF);
        do_req(1'b0, 2'd0, 32'h0000_0100, 32'd0);
        check("r32_data", cpu_rd_data, 32'hDEAD_BEEF);

        // 16-bit and 8-bit sizes, with neighbours preloaded.
        do_req(1'b1, 2'd2, 32'h0000_0200, 32'h0000_0055);
        do_req(1'b1, 2'd2, 32'h0000_0203, 32'hFFFF_FF66);
        do_req(1'b1, 2'd1, 32'h0000_0201, 32'h1234_ABCD);
        check("w16_b200", {24'd0, ram_byte(24'h000200)}, 32'h55);
        check("w16_b201", {24'd0, ram_byte(24'h000201)}, 32'hAB);
        check("w16_b202", {24'd0, ram_byte(24'h000202)}, 32'hCD);
        check("w16_b203", {24'd0, ram_byte(24'h000203)}, 32'h66);
        do_req(1'b0, 2'd2, 32'h0000_0202, 32'd0);
        check("r8_data", cpu_rd_data, 32'h0000_00CD);
        do_req(1'b0, 2'd3, 32'h0000_0201, 32'd0);
        check("r8s3_data", cpu_rd_data, 32'h0000_00AB);
        do_req(1'b1, 2'd3, 32'h0000_0204, 32'hAABB_CC77);
        check("w8s3_b204", {24'd0, ram_byte(24'h000204)}, 32'h77);
        check("w8s3_b205", {24'd0, ram_byte(24'h000205)}, 32'h00);

        // Address wrap at the top of the 24-bit space.
        do_req(1'b1, 2'd0, 32'hFFFF_FFFE, 32'h1122_3344);
        check("wrap_b0", {24'd0, ram_byte(24'hFFFFFE)}, 32'h11);
        check("wrap_b1", {24'd0, ram_byte(24'hFFFFFF)}, 32'h22);
        check("wrap_b2", {24'd0, ram_byte(24'h000000)}, 32'h33);
        check("wrap_b3", {24'd0, ram_byte(24'h000001)}, 32'h44);
        do_req(1'b0, 2'd0, 32'h00FF_FFFE, 32'd0);

        // Request held high; inputs change mid-transfer and become the next request.
        wait_idle();
        cpu_req     = 1'b1;
        cpu_write   = 1'b1;
        cpu_size    = 2'd0;
        cpu_addr    = 32'h0000_0400;
        cpu_wr_data = 32'hA1B2_C3D4;
        @(posedge clk);
        #1;
        model_push(1'b1, 2'd0, 32'h0000_0400, 32'hA1B2_C3D4, cyc);
        @(negedge clk);
        cpu_addr    = 32'h0000_0500;
        cpu_wr_data = 32'h0BAD_CAFE;
        wait_ack();
        @(negedge clk);
        check("hold_idle_gap", {31'd0, cpu_busy}, 32'd0);
        @(posedge clk);
        #1;
        a       = cyc;
        cpu_req = 1'b0;
        model_push(1'b1, 2'd0, 32'h0000_0500, 32'h0BAD_CAFE, a);
        @(negedge clk);
        check("hold_second_busy", {31'd0, cpu_busy}, 32'd1);
        wait_ack();
        check("hold_b400", {24'd0, ram_byte(24'h000400)}, 32'hA1);
        check("hold_b500", {24'd0, ram_byte(24'h000500)}, 32'h0B);
        do_req(1'b0, 2'd0, 32'h0000_0400, 32'd0);
        do_req(1'b0, 2'd0, 32'h0000_0500, 32'd0);

        // Reset after two bytes of a 32-bit write.
        wait_idle();
        cpu_req     = 1'b1;
        cpu_write   = 1'b1;
        cpu_size    = 2'd0;
        cpu_addr    = 32'h0000_0300;
        cpu_wr_data = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        ref_mem[32'h300] = 8'hCA;
        ref_mem[32'h301] = 8'hFE;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_busy", {31'd0, cpu_busy}, 32'd0);
        check("rst_mid_wr_en", {31'd0, ram_wr_en}, 32'd0);
        check("rst_mid_rd_data", cpu_rd_data, 32'd0);
        last_rd = 32'd0;
        rst_n   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_b300", {24'd0, ram_byte(24'h000300)}, 32'hCA);
        check("rst_mid_b301", {24'd0, ram_byte(24'h000301)}, 32'hFE);
        check("rst_mid_b302", {24'd0, ram_byte(24'h000302)}, 32'h00);
        check("rst_mid_b303", {24'd0, ram_byte(24'h000303)}, 32'h00);
        do_req(1'b0, 2'd0, 32'h0000_0300, 32'd0);
        check("rst_mid_read", cpu_rd_data, 32'hCAFE_0000);

        // Randomised traffic over a small window and the top-of-memory wrap.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] addr;
            if ($urandom_range(3, 0) == 0)
                addr = ($urandom & 32'hFF00_0000) | 32'(24'hFFFFFC + 24'($urandom_range(3, 0)));
            else
                addr = ($urandom & 32'hFF00_0000) | (32'h600 + 32'($urandom_range(31, 0)));
            do_req(1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), addr, $urandom);
        end

        // Whole-memory comparison against the reference.
        repeat (3) @(negedge clk);
        foreach (ref_mem[k]) check("mem_ref", {24'd0, ram_byte(k[23:0])}, {24'd0, ref_mem[k]});
        foreach (ram[k]) check("mem_ram", {24'd0, ram[k]}, {24'd0, ref_byte(k[23:0])});
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
